ibex_fetch_req_ctrl: RTL and testbench
======================================

Name: ibex_fetch_req_ctrl

Overview:
- Sequences instruction-memory requests on behalf of the 32-bit fetch FIFO. Sits between the instruction bus (req/gnt/rvalid) and the FIFO.
- Issues word-aligned fetches and tracks up to NUM_REQS outstanding responses.
- Throttles issue using FIFO occupancy. On a branch it clears the FIFO and discards in-flight responses.

Parameters:
- NUM_REQS, 2: max outstanding bus requests; must match the FIFO's NUM_REQS; legal range 1..4.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous, active-low reset
- req_i  in  1  fetch enable from core control
- branch_i  in  1  redirect fetch to addr_i this cycle
- addr_i  in  32  branch target (bit 0 ignored)
- busy_o  out  1  any request pending or outstanding
- instr_req_o  out  1  bus request
- instr_gnt_i  in  1  bus grant
- instr_addr_o  out  32  bus address, bits [1:0] always 0
- instr_rvalid_i  in  1  bus response valid
- instr_rdata_i  in  32  bus response data
- instr_err_i  in  1  bus response error
- fifo_clear_o  out  1  FIFO clear
- fifo_busy_i  in  NUM_REQS  FIFO upper-entry occupancy
- fifo_valid_o  out  1  push response into FIFO
- fifo_addr_o  out  32  address loaded into FIFO on clear
- fifo_rdata_o  out  32  response data to FIFO
- fifo_err_o  out  1  response error to FIFO
- perf_discard_o  out  16  count of discarded responses (see optional feature)

Behaviour:
- Reset: instr_req_o=0, instr_addr_o=0, busy_o=0, fifo_valid_o=0, fifo_clear_o=0, perf_discard_o=0. State IDLE, all outstanding and discard bits 0, fetch_addr_q=0.
- State machine has two states:
  - IDLE: no unGranted request held.
  - WAIT_GNT: instr_req_o held high with instr_addr_o stable until instr_gnt_i.
- Issue condition:
  - Let out_cnt = popcount(outstanding_q) and fifo_cnt = popcount(fifo_busy_i).
  - can_issue = req_i & (out_cnt < NUM_REQS) & (branch_i | (out_cnt + fifo_cnt < NUM_REQS)).
  - On branch_i, fifo_cnt is treated as 0.
- instr_req_o = can_issue | (state==WAIT_GNT). A request already in WAIT_GNT is never withdrawn, even if req_i falls.
- instr_addr_o:
  - branch_i: {addr_i[31:2],2'b00}.
  - WAIT_GNT without branch: held address.
  - otherwise: fetch_addr_q.
- Branch during WAIT_GNT: address switches to the new target in the same cycle; request stays high.
- Transitions:
  - IDLE -> WAIT_GNT when instr_req_o & ~instr_gnt_i.
  - WAIT_GNT -> IDLE on instr_gnt_i.
  - A grant in the same cycle as the request stays in IDLE.
- On grant: fetch_addr_q <= instr_addr_o + 4, 32-bit wrap-around (0xFFFFFFFC -> 0x0).
- Outstanding tracking:
  - outstanding_q is an ordered shift vector; index 0 is the oldest.
  - Grant pushes at the lowest free index; rvalid pops index 0.
  - Simultaneous grant and rvalid shifts and pushes in one cycle.
  - rvalid with no outstanding request is illegal (assertion).
- Discard:
  - branch_i sets discard_q for every currently outstanding entry.
  - A grant in the branch cycle belongs to the new stream and is not discarded.
  - A discarded response is consumed without asserting fifo_valid_o.
- FIFO side:
  - fifo_clear_o = branch_i, combinational; fifo_addr_o = addr_i.
  - fifo_valid_o = instr_rvalid_i & outstanding_q[0] & ~discard_q[0], combinational, zero latency.
  - fifo_rdata_o = instr_rdata_i, fifo_err_o = instr_err_i.
  - A valid response in the branch cycle is dropped: fifo_valid_o is gated by ~branch_i.
- busy_o = |outstanding_q | instr_req_o.
- Reset mid-operation: all state cleared asynchronously. Responses arriving after reset are illegal.

Optional Feature:
- IBEX_FETCH_PERF_EN defined: perf_discard_o is a 16-bit saturating counter, +1 per discarded response, holds at 0xFFFF.
- Undefined: perf_discard_o tied to 0 and no counter flops exist.

Decomposition:
- Shared package ibex_fetch_pkg holds:
  - typedef fetch_state_e {FETCH_IDLE, FETCH_WAIT_GNT};
  - constant FETCH_WORD_BYTES=4;
  - constant MAX_FETCH_REQS=4.
- One natural sub-module, ibex_fetch_outstanding_tracker: ordered outstanding/discard bit vectors with push/pop/branch-mark. The FSM and address logic stay in the top.

Test Plan:
- Reset then req_i=1, branch_i=1 addr_i=0x80; gnt same cycle -> instr_addr_o=0x80, next request 0x84, fifo_clear_o=1 in branch cycle.
- gnt held low 3 cycles -> instr_req_o stays 1, instr_addr_o stable at 0x84; after gnt, next address 0x88.
- NUM_REQS=2, two granted requests with no rvalid -> instr_req_o=0; one rvalid -> request reissued next cycle; fifo_valid_o pulses with rdata 0xDEADBEEF.
- Two outstanding requests, branch to 0x200, then both rvalid -> fifo_valid_o stays 0 for both. First valid push is 0x200 data. With IBEX_FETCH_PERF_EN, perf_discard_o=2.
- fifo_busy_i=2'b11 with out_cnt=0 -> no request. Same plus branch_i -> request issued at branch target.
- Sequential fetch from 0xFFFFFFF8 -> addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.

Source files
------------

// File: rtl/ibex_fetch_pkg.sv
// Shared types and constants for the instruction fetch request controller.
package ibex_fetch_pkg;

    typedef enum logic {
        FETCH_IDLE,
        FETCH_WAIT_GNT
    } fetch_state_e;

    localparam int unsigned FETCH_WORD_BYTES = 4;
    localparam int unsigned MAX_FETCH_REQS   = 4;

    function automatic logic [2:0] popcount_reqs(input logic [MAX_FETCH_REQS-1:0] v);
        logic [2:0] cnt;
        cnt = '0;
        for (int i = 0; i < MAX_FETCH_REQS; i++) begin
            cnt = cnt + {2'b00, v[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/ibex_fetch_outstanding_tracker.sv
// Ordered record of granted-but-unanswered fetches (index 0 oldest) plus a
// per-entry discard mark set on redirect; updates in one cycle, never stalls.
module ibex_fetch_outstanding_tracker
    import ibex_fetch_pkg::*;
#(
    parameter int unsigned NUM_REQS = 2
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                push,
    input  logic                pop,
    input  logic                mark,
    output logic [NUM_REQS-1:0] outstanding,
    output logic [NUM_REQS-1:0] discard
);

    logic [NUM_REQS-1:0] outstanding_q, outstanding_d;
    logic [NUM_REQS-1:0] discard_q, discard_d;
    logic                placed;

    // Order matters: mark the old stream, retire the head, then append the
    // new grant so a grant in the redirect cycle is never marked.
    always_comb begin
        outstanding_d = outstanding_q;
        discard_d     = discard_q;
        placed        = 1'b0;
        if (mark) begin
            discard_d = outstanding_q;
        end
        if (pop) begin
            outstanding_d = outstanding_d >> 1;
            discard_d     = discard_d >> 1;
        end
        if (push) begin
            for (int i = 0; i < NUM_REQS; i++) begin
                if (!outstanding_d[i] && !placed) begin
                    outstanding_d[i] = 1'b1;
                    discard_d[i]     = 1'b0;
                    placed           = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

    assign outstanding = outstanding_q;
    assign discard     = discard_q;

    a_pop_needs_outstanding: assert property (
        @(posedge clk_i) disable iff (!rst_ni) pop |-> outstanding_q[0]
    );

endmodule

// File: rtl/ibex_fetch_req_ctrl.sv
// Instruction fetch request sequencer between the bus and the fetch FIFO.
// Optional discard performance counter enabled by IBEX_FETCH_PERF_EN.
module ibex_fetch_req_ctrl
    import ibex_fetch_pkg::*;
#(
    parameter int unsigned NUM_REQS = 2
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                req_i,
    input  logic                branch_i,
    input  logic [31:0]         addr_i,
    output logic                busy_o,
    output logic                instr_req_o,
    input  logic                instr_gnt_i,
    output logic [31:0]         instr_addr_o,
    input  logic                instr_rvalid_i,
    input  logic [31:0]         instr_rdata_i,
    input  logic                instr_err_i,
    output logic                fifo_clear_o,
    input  logic [NUM_REQS-1:0] fifo_busy_i,
    output logic                fifo_valid_o,
    output logic [31:0]         fifo_addr_o,
    output logic [31:0]         fifo_rdata_o,
    output logic                fifo_err_o,
    output logic [15:0]         perf_discard_o
);

    localparam logic [3:0] REQ_LIMIT = 4'(NUM_REQS);

    fetch_state_e        state_q, state_d;
    logic [31:0]         fetch_addr_q;
    logic [31:0]         branch_addr;
    logic [NUM_REQS-1:0] outstanding;
    logic [NUM_REQS-1:0] discard;
    logic [2:0]          out_cnt;
    logic [2:0]          fifo_cnt;
    logic                can_issue;
    logic                granted;

    assign branch_addr = {addr_i[31:2], 2'b00};
    assign out_cnt     = popcount_reqs(MAX_FETCH_REQS'(outstanding));
    assign fifo_cnt    = popcount_reqs(MAX_FETCH_REQS'(fifo_busy_i));
    assign can_issue   = req_i
                       & ({1'b0, out_cnt} < REQ_LIMIT)
                       & (branch_i | (({1'b0, out_cnt} + {1'b0, fifo_cnt}) < REQ_LIMIT));
    assign granted     = instr_req_o & instr_gnt_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= FETCH_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH_IDLE:     if (instr_req_o && !instr_gnt_i) state_d = FETCH_WAIT_GNT;
            FETCH_WAIT_GNT: if (instr_gnt_i)                 state_d = FETCH_IDLE;
            default:        state_d = FETCH_IDLE;
        endcase
    end

    // fetch_addr_q doubles as the held address while waiting for a grant:
    // it is not updated until that grant, and an ungranted redirect loads it.
    always_comb begin
        instr_req_o  = can_issue | (state_q == FETCH_WAIT_GNT);
        instr_addr_o = branch_i ? branch_addr : fetch_addr_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fetch_addr_q <= '0;
        end else if (granted) begin
            fetch_addr_q <= instr_addr_o + 32'(FETCH_WORD_BYTES);
        end else if (branch_i) begin
            fetch_addr_q <= branch_addr;
        end
    end

    ibex_fetch_outstanding_tracker #(
        .NUM_REQS (NUM_REQS)
    ) u_tracker (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .push        (granted),
        .pop         (instr_rvalid_i),
        .mark        (branch_i),
        .outstanding (outstanding),
        .discard     (discard)
    );

    assign fifo_clear_o = branch_i;
    assign fifo_addr_o  = addr_i;
    assign fifo_valid_o = instr_rvalid_i & outstanding[0] & ~discard[0] & ~branch_i;
    assign fifo_rdata_o = instr_rdata_i;
    assign fifo_err_o   = instr_err_i;
    assign busy_o       = (|outstanding) | instr_req_o;

`ifdef IBEX_FETCH_PERF_EN
    logic        discard_evt;
    logic [15:0] perf_discard_q;

    // A response landing in the redirect cycle is dropped too, so it counts.
    assign discard_evt = instr_rvalid_i & outstanding[0] & (discard[0] | branch_i);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_discard_q <= '0;
        end else if (discard_evt && (perf_discard_q != 16'hFFFF)) begin
            perf_discard_q <= perf_discard_q + 16'd1;
        end
    end

    assign perf_discard_o = perf_discard_q;
`else
    assign perf_discard_o = '0;
`endif

endmodule

// File: tb/tb_ibex_fetch_req_ctrl.sv
// Directed bench for ibex_fetch_req_ctrl with NUM_REQS=2.
module tb_ibex_fetch_req_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        req_i;
    logic        branch_i;
    logic [31:0] addr_i;
    logic        busy_o;
    logic        instr_req_o;
    logic        instr_gnt_i;
    logic [31:0] instr_addr_o;
    logic        instr_rvalid_i;
    logic [31:0] instr_rdata_i;
    logic        instr_err_i;
    logic        fifo_clear_o;
    logic [1:0]  fifo_busy_i;
    logic        fifo_valid_o;
    logic [31:0] fifo_addr_o;
    logic [31:0] fifo_rdata_o;
    logic        fifo_err_o;
    logic [15:0] perf_discard_o;

    int n_cmp = 0;
    int n_bad = 0;

`ifdef IBEX_FETCH_PERF_EN
    localparam logic [15:0] EXP_PERF = 16'd2;
`else
    localparam logic [15:0] EXP_PERF = 16'd0;
`endif

    always #5 clk_i = ~clk_i;

    ibex_fetch_req_ctrl #(.NUM_REQS(2)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .req_i          (req_i),
        .branch_i       (branch_i),
        .addr_i         (addr_i),
        .busy_o         (busy_o),
        .instr_req_o    (instr_req_o),
        .instr_gnt_i    (instr_gnt_i),
        .instr_addr_o   (instr_addr_o),
        .instr_rvalid_i (instr_rvalid_i),
        .instr_rdata_i  (instr_rdata_i),
        .instr_err_i    (instr_err_i),
        .fifo_clear_o   (fifo_clear_o),
        .fifo_busy_i    (fifo_busy_i),
        .fifo_valid_o   (fifo_valid_o),
        .fifo_addr_o    (fifo_addr_o),
        .fifo_rdata_o   (fifo_rdata_o),
        .fifo_err_o     (fifo_err_o),
        .perf_discard_o (perf_discard_o)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Apply one cycle of stimulus on the falling edge; checks follow #1 later.
    task automatic drive(input logic req, input logic br, input logic [31:0] addr,
                         input logic gnt, input logic rv, input logic [31:0] rdata,
                         input logic [1:0] fbusy);
        @(negedge clk_i);
        req_i          = req;
        branch_i       = br;
        addr_i         = addr;
        instr_gnt_i    = gnt;
        instr_rvalid_i = rv;
        instr_rdata_i  = rdata;
        fifo_busy_i    = fbusy;
        #1;
    endtask

    initial begin
        rst_ni = 1'b0;
        req_i = 1'b0; branch_i = 1'b0; addr_i = '0; instr_gnt_i = 1'b0;
        instr_rvalid_i = 1'b0; instr_rdata_i = '0; instr_err_i = 1'b0; fifo_busy_i = '0;
        #2;
        check_val("rst_req",   {31'd0, instr_req_o},  32'd0);
        check_val("rst_addr",  instr_addr_o,          32'd0);
        check_val("rst_busy",  {31'd0, busy_o},       32'd0);
        check_val("rst_valid", {31'd0, fifo_valid_o}, 32'd0);
        check_val("rst_clear", {31'd0, fifo_clear_o}, 32'd0);
        check_val("rst_perf",  {16'd0, perf_discard_o}, 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Branch to 0x80 granted immediately
        drive(1, 1, 32'h80, 1, 0, 0, 2'b00);
        check_val("br_req",   {31'd0, instr_req_o},  32'd1);
        check_val("br_addr",  instr_addr_o,          32'h80);
        check_val("br_clear", {31'd0, fifo_clear_o}, 32'd1);
        check_val("br_faddr", fifo_addr_o,           32'h80);

        // Grant withheld three cycles; request and address held even with req_i low
        drive(1, 0, 0, 0, 0, 0, 2'b00);
        check_val("seq_addr",   instr_addr_o,          32'h84);
        check_val("seq_clear",  {31'd0, fifo_clear_o}, 32'd0);
        drive(0, 0, 0, 0, 0, 0, 2'b00);
        check_val("hold_req1",  {31'd0, instr_req_o},  32'd1);
        check_val("hold_addr1", instr_addr_o,          32'h84);
        drive(0, 0, 0, 0, 0, 0, 2'b00);
        check_val("hold_addr2", instr_addr_o,          32'h84);
        check_val("hold_busy",  {31'd0, busy_o},       32'd1);
        drive(0, 0, 0, 1, 0, 0, 2'b00);
        check_val("hold_req3",  {31'd0, instr_req_o},  32'd1);
        check_val("hold_addr3", instr_addr_o,          32'h84);

        // Two outstanding: throttled until a response retires one
        drive(1, 0, 0, 0, 0, 0, 2'b00);
        check_val("full_req",   {31'd0, instr_req_o},  32'd0);
        check_val("full_addr",  instr_addr_o,          32'h88);
        drive(1, 0, 0, 0, 1, 32'hDEADBEEF, 2'b00);
        check_val("rsp_valid",  {31'd0, fifo_valid_o}, 32'd1);
        check_val("rsp_rdata",  fifo_rdata_o,          32'hDEADBEEF);
        check_val("rsp_req",    {31'd0, instr_req_o},  32'd0);
        drive(1, 0, 0, 1, 0, 0, 2'b00);
        check_val("reiss_req",  {31'd0, instr_req_o},  32'd1);
        check_val("reiss_addr", instr_addr_o,          32'h88);

        // Redirect with two in flight; both responses are discarded
        drive(1, 1, 32'h201, 0, 0, 0, 2'b00);
        check_val("br2_addr",   instr_addr_o,          32'h200);
        check_val("br2_faddr",  fifo_addr_o,           32'h201);
        check_val("br2_req",    {31'd0, instr_req_o},  32'd0);
        drive(1, 0, 0, 0, 1, 32'h11111111, 2'b00);
        check_val("disc_valid1", {31'd0, fifo_valid_o}, 32'd0);
        drive(1, 0, 0, 1, 1, 32'h22222222, 2'b00);
        check_val("disc_valid2", {31'd0, fifo_valid_o}, 32'd0);
        check_val("tgt_req",     {31'd0, instr_req_o},  32'd1);
        check_val("tgt_addr",    instr_addr_o,          32'h200);
        drive(0, 0, 0, 0, 1, 32'h200DA7A0, 2'b00);
        check_val("tgt_valid",   {31'd0, fifo_valid_o}, 32'd1);
        check_val("tgt_rdata",   fifo_rdata_o,          32'h200DA7A0);
        check_val("perf_cnt",    {16'd0, perf_discard_o}, {16'd0, EXP_PERF});
        drive(0, 0, 0, 0, 0, 0, 2'b00);
        check_val("idle_busy",   {31'd0, busy_o},       32'd0);

        // FIFO occupancy throttle, overridden by a branch; then address wrap
        drive(1, 0, 0, 0, 0, 0, 2'b11);
        check_val("fthr_req",    {31'd0, instr_req_o},  32'd0);
        drive(1, 1, 32'hFFFFFFF8, 1, 0, 0, 2'b11);
        check_val("fbr_req",     {31'd0, instr_req_o},  32'd1);
        check_val("wrap_addr0",  instr_addr_o,          32'hFFFFFFF8);
        drive(1, 0, 0, 1, 1, 32'h33333333, 2'b00);
        check_val("wrap_addr1",  instr_addr_o,          32'hFFFFFFFC);
        check_val("wrap_valid",  {31'd0, fifo_valid_o}, 32'd1);
        drive(1, 0, 0, 0, 0, 0, 2'b00);
        check_val("wrap_addr2",  instr_addr_o,          32'h00000000);
        check_val("wrap_req",    {31'd0, instr_req_o},  32'd1);

        // Asynchronous reset in the middle of a pending request
        @(negedge clk_i);
        req_i = 1'b0;
        rst_ni = 1'b0;
        #1;
        check_val("mid_rst_req",  {31'd0, instr_req_o}, 32'd0);
        check_val("mid_rst_busy", {31'd0, busy_o},      32'd0);
        check_val("mid_rst_addr", instr_addr_o,         32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
